icache_fill_ctrl: RTL and testbench

- CPU-side instruction cache and line-fill initiator for the instruction-memory burst interface.
- On a miss, drives instrreq/instradr, consumes the val/instr beat stream from the memory model and fills a direct-mapped line.
- Presents fetched instructions to the pipeline fetch stage and holds the pipeline via fetch_rdy low until a hit.

---
 rtl/icache_fill_ctrl.sv | 153 +++++++++++++++
 tb/tb_icache_fill_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fill_ctrl.sv
// Direct-mapped instruction cache with a burst line-fill controller toward instruction memory.
// Build with ICACHE_STATS_EN defined to add the hit_cnt / miss_cnt statistics outputs.
//
// state | meaning
// IDLE  | serving hits; a miss latches the line address and raises instrreq
// FILL  | burst in flight, one word captured per val beat into the latched line
// DRAIN | burst done, waiting for val to fall before a new request may issue
module icache_fill_ctrl #(
    parameter int LINES = 8,
    parameter int BEATS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fetch_pc,
    input  logic        fetch_req,
    output logic [31:0] fetch_instr,
    output logic        fetch_rdy,
    input  logic        flush,
    output logic        busy,
    output logic        instrreq,
    output logic [31:0] instradr,
    input  logic        val,
    input  logic [31:0] instr
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int WORD_W = $clog2(BEATS);
    localparam int IDX_W  = $clog2(LINES);
    localparam int OFF_W  = WORD_W + 2;
    localparam int TAG_W  = 32 - OFF_W - IDX_W;
    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [31:0]       data_mem [LINES*BEATS];
    logic [TAG_W-1:0]  tag_mem [LINES];
    logic [LINES-1:0]  valid;
    logic              flush_pending;
    logic [WORD_W-1:0] beat;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;

    logic [WORD_W-1:0] pc_word;
    logic [IDX_W-1:0]  pc_idx;
    logic [TAG_W-1:0]  pc_tag;
    logic              hit;
    logic              start_fill;
    logic              unused_pc_bits;

    assign pc_word        = fetch_pc[OFF_W-1:2];
    assign pc_idx         = fetch_pc[OFF_W+IDX_W-1:OFF_W];
    assign pc_tag         = fetch_pc[31:OFF_W+IDX_W];
    assign unused_pc_bits = ^fetch_pc[1:0];

    // A flush cycle never reports a hit, so nothing is served from lines being invalidated.
    assign hit         = fetch_req && !flush && valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
    assign fetch_rdy   = hit;
    assign fetch_instr = hit ? data_mem[{pc_idx, pc_word}] : 32'd0;
    assign start_fill  = (state == IDLE) && fetch_req && !flush && !hit;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            instrreq      <= 1'b0;
            instradr      <= 32'd0;
            beat          <= '0;
            valid         <= '0;
            flush_pending <= 1'b0;
            fill_idx      <= '0;
            fill_tag      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    flush_pending <= 1'b0;
                    if (flush) begin
                        valid <= '0;
                    end else if (start_fill) begin
                        state            <= FILL;
                        fill_idx         <= pc_idx;
                        fill_tag         <= pc_tag;
                        instradr         <= {fetch_pc[31:OFF_W], {OFF_W{1'b0}}};
                        instrreq         <= 1'b1;
                        beat             <= '0;
                        // the victim line is overwritten in place, so it must stop hitting now
                        valid[pc_idx]    <= 1'b0;
                    end
                end
                FILL: begin
                    if (flush) begin
                        valid         <= '0;
                        flush_pending <= 1'b1;
                    end
                    if (val) begin
                        beat <= beat + 1'b1;
                        if (beat == LAST_BEAT) begin
                            valid[fill_idx] <= !flush_pending && !flush;
                            instrreq        <= 1'b0;
                            state           <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (flush) begin
                        valid         <= '0;
                        flush_pending <= 1'b1;
                    end
                    if (!val) begin
                        state         <= IDLE;
                        flush_pending <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data and tag storage carry no reset; the valid bits alone decide what may hit.
    always_ff @(posedge clk) begin
        if (!reset && (state == FILL) && val) begin
            data_mem[{fill_idx, beat}] <= instr;
            if (beat == LAST_BEAT) begin
                tag_mem[fill_idx] <= fill_tag;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else begin
            if (hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (start_fill) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Scoreboard bench for icache_fill_ctrl: stimulus queues expected hits and burst addresses,
// monitors pop and compare; a burst responder model supplies memory words.
module tb_icache_fill_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] fetch_pc = 32'd0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_instr;
    logic        fetch_rdy;
    logic        flush = 1'b0;
    logic        busy;
    logic        instrreq;
    logic [31:0] instradr;
    logic        val = 1'b0;
    logic [31:0] instr = 32'd0;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    icache_fill_ctrl #(.LINES(8), .BEATS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_pc   (fetch_pc),
        .fetch_req  (fetch_req),
        .fetch_instr(fetch_instr),
        .fetch_rdy  (fetch_rdy),
        .flush      (flush),
        .busy       (busy),
        .instrreq   (instrreq),
        .instradr   (instradr),
        .val        (val),
        .instr      (instr)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_hit_q [$];
    logic [31:0] exp_adr_q [$];
    bit          hold_mode = 1'b0;
    logic [31:0] hold_exp = 32'd0;
    int          hold_hits = 0;
    int          burst_cnt = 0;
    bit          chk_last = 1'b0;
    logic        prev_req = 1'b0;
    logic        prev_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] b2w(input bit b);
        return b ? 32'd1 : 32'd0;
    endfunction

    // Memory contents: word at byte address A is 0x0FF0 + A/4 (0x40 -> 0x1000).
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_0FF0 + {2'b00, a[31:2]};
    endfunction

    // Responder: sees instrreq, leaves one idle cycle, then 8 consecutive beats.
    initial begin : responder
        logic        rq;
        logic        rs;
        logic [31:0] ra;
        logic [31:0] base;
        int          k;
        bit          act;
        act  = 1'b0;
        k    = 0;
        base = 32'd0;
        forever begin
            @(negedge clk);
            rq = instrreq;
            rs = reset;
            ra = instradr;
            @(posedge clk);
            #1;
            if (rs) begin
                act = 1'b0;
                val = 1'b0;
            end else if (!act) begin
                if (rq) begin
                    act   = 1'b1;
                    base  = ra;
                    instr = mem_word(base);
                    val   = 1'b1;
                    k     = 1;
                    burst_cnt++;
                end else begin
                    val = 1'b0;
                end
            end else if (k < 8) begin
                instr = mem_word(base + 32'(4 * k));
                k++;
            end else begin
                val      = 1'b0;
                act      = 1'b0;
                chk_last = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (fetch_rdy) begin
            if (hold_mode) begin
                hold_hits++;
                chk("hold_hit_data", fetch_instr, hold_exp);
            end else if (exp_hit_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_hit: got fetch_rdy=1 instr 0x%08h, expected no hit", fetch_instr);
            end else begin
                chk("hit_data", fetch_instr, exp_hit_q.pop_front());
            end
        end
        if (instrreq && !prev_req) begin
            chk("busy_low_before_burst", b2w(prev_busy), 32'd0);
            if (exp_adr_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_burst: got instradr 0x%08h, expected no burst", instradr);
            end else begin
                chk("burst_adr", instradr, exp_adr_q.pop_front());
            end
        end
        if (chk_last) begin
            chk("req_low_after_last_beat", b2w(instrreq), 32'd0);
            chk_last = 1'b0;
        end
        prev_req  = instrreq;
        prev_busy = busy;
    end

    // Called at posedge+1; returns at posedge+1 after the cycle that hit, fetch_req left high.
    task automatic issue(input logic [31:0] pc, input logic [31:0] exp, input bit miss, output int lat);
        bit got;
        if (miss) exp_adr_q.push_back({pc[31:5], 5'b0});
        exp_hit_q.push_back(exp);
        fetch_pc  = pc;
        fetch_req = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            @(negedge clk);
            if (fetch_rdy) got = 1'b1;
            else lat++;
        end
        if (!got) begin
            void'(exp_hit_q.pop_back());
            chk("hit_timeout", 32'(lat), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int lat;
        int b0;
        int n;
        fetch_req = 1'b1;
        fetch_pc  = 32'h40;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_fetch_rdy", b2w(fetch_rdy), 32'd0);
        chk("rst_instrreq", b2w(instrreq), 32'd0);
        chk("rst_instradr", instradr, 32'd0);
        chk("rst_busy", b2w(busy), 32'd0);
`ifdef ICACHE_STATS_EN
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        reset     = 1'b0;
        fetch_req = 1'b0;
        @(posedge clk);
        #1;

        // cold miss then every word of the line
        issue(32'h40, 32'h1000, 1'b1, lat);
        chk("cold_miss_latency", b2w(lat >= 9 && lat <= 14), 32'd1);
        for (int i = 0; i < 8; i++) begin
            issue(32'h40 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0, lat);
            chk("line_hit_latency", 32'(lat), 32'd0);
        end
        fetch_req = 1'b0;

        // flush in IDLE with a request on a valid line
        fetch_pc  = 32'h40;
        fetch_req = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        chk("flush_idle_no_hit", b2w(fetch_rdy), 32'd0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        fetch_req = 1'b0;
        @(negedge clk);
        chk("flush_idle_no_fill", b2w(busy), 32'd0);
        @(posedge clk);
        #1;
        issue(32'h40, 32'h1000, 1'b1, lat);
        chk("refill_after_flush", b2w(lat >= 9), 32'd1);

        // conflict eviction on index 2
        issue(32'h140, 32'h1040, 1'b1, lat);
        chk("conflict_miss", b2w(lat >= 9), 32'd1);
        issue(32'h40, 32'h1000, 1'b1, lat);
        chk("evicted_line_missed", b2w(lat >= 9), 32'd1);
        fetch_req = 1'b0;

        // flush during beat 4 of the fill at 0x80: two bursts before the hit
        exp_adr_q.push_back(32'h80);
        fork
            issue(32'h80, 32'h1010, 1'b1, lat);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!(val && instr == 32'h1013) && n < 100);
                chk("flush_beat_found", b2w(n < 100), 32'd1);
                @(posedge clk);
                #1;
                flush = 1'b1;
                @(posedge clk);
                #1;
                flush = 1'b0;
            end
        join
        chk("flushed_fill_reissued", b2w(lat >= 18), 32'd1);
        issue(32'h84, 32'h1011, 1'b0, lat);
        chk("refilled_line_hits", 32'(lat), 32'd0);
        fetch_req = 1'b0;

        // held request on a missing pc: exactly one burst
        b0        = burst_cnt;
        hold_hits = 0;
        hold_exp  = 32'h10B0;
        hold_mode = 1'b1;
        exp_adr_q.push_back(32'h300);
        fetch_pc  = 32'h300;
        fetch_req = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        fetch_req = 1'b0;
        hold_mode = 1'b0;
        chk("bursts_per_held_miss", 32'(burst_cnt - b0), 32'd1);
        chk("held_hits_seen", b2w(hold_hits >= 15), 32'd1);
`ifdef ICACHE_STATS_EN
        chk("miss_cnt_total", miss_cnt, 32'd7);
`endif

        // reset at beat 3 of a fill at 0x200
        exp_adr_q.push_back(32'h200);
        fetch_pc  = 32'h200;
        fetch_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(val && instr == 32'h1073) && n < 100);
        chk("reset_beat_found", b2w(n < 100), 32'd1);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        fetch_req = 1'b0;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        fetch_pc  = 32'h84;
        fetch_req = 1'b1;
        exp_adr_q.push_back(32'h80);
        @(negedge clk);
        chk("midfill_rst_instrreq", b2w(instrreq), 32'd0);
        chk("midfill_rst_busy", b2w(busy), 32'd0);
        chk("midfill_rst_line_invalid", b2w(fetch_rdy), 32'd0);
`ifdef ICACHE_STATS_EN
        chk("midfill_rst_hit_cnt", hit_cnt, 32'd0);
        chk("midfill_rst_miss_cnt", miss_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        issue(32'h84, 32'h1011, 1'b0, lat);
        fetch_req = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        chk("hit_queue_drained", 32'(exp_hit_q.size()), 32'd0);
        chk("burst_queue_drained", 32'(exp_adr_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
